// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the CPU register file: takes host read/write/dump
// commands while the core is halted and returns one response beat per access.
module regfile_debug_port #(
  parameter int unsigned BITS  = 16,
  parameter int unsigned RBITS = 4,
  parameter int unsigned NREG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_halted,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RBITS-1:0] cmd_addr,
  input  logic [BITS-1:0]  cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RBITS-1:0] rsp_addr,
  output logic [BITS-1:0]  rsp_data,
  output logic             rsp_last,
  output logic             rf_we,
  output logic [RBITS-1:0] rf_rd,
  output logic [BITS-1:0]  rf_rd_din,
  output logic [RBITS-1:0] rf_rs,
  input  logic [BITS-1:0]  rf_rs_dout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0]       OP_READ  = 2'b01;
  localparam logic [1:0]       OP_WRITE = 2'b10;
  localparam logic [1:0]       OP_DUMP  = 2'b11;
  localparam logic [RBITS-1:0] LAST_IDX = RBITS'(NREG - 1);

  state_e           state_q, state_d;
  logic             accept;
  logic             dump_q, dump_d;
  logic [RBITS-1:0] idx_q, idx_d;
  logic [RBITS-1:0] rf_rd_q, rf_rd_d;
  logic [BITS-1:0]  rf_rd_din_q, rf_rd_din_d;
  logic [RBITS-1:0] rsp_addr_q, rsp_addr_d;
  logic [BITS-1:0]  rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ, OP_DUMP: state_d = READ;
            OP_WRITE:         state_d = WRITE;
            default:          state_d = IDLE;
          endcase
        end
      end
      WRITE, READ: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = (dump_q && (idx_q != LAST_IDX)) ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = core_halted && (state_q == IDLE) && !reset;
    rf_we     = (state_q == WRITE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign accept = cmd_valid && cmd_ready;

  // Datapath next values; dump ends on compare with the last index, not on wrap
  always_comb begin
    dump_d      = dump_q;
    idx_d       = idx_q;
    rf_rd_d     = rf_rd_q;
    rf_rd_din_d = rf_rd_din_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ: begin
              idx_d  = cmd_addr;
              dump_d = 1'b0;
            end
            OP_WRITE: begin
              rf_rd_d     = cmd_addr;
              rf_rd_din_d = cmd_wdata;
            end
            OP_DUMP: begin
              idx_d  = '0;
              dump_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        rsp_addr_d = rf_rd_q;
        rsp_data_d = rf_rd_din_q;
        rsp_last_d = 1'b1;
      end
      READ: begin
        rsp_addr_d = idx_q;
        rsp_data_d = rf_rs_dout;
        rsp_last_d = !dump_q || (idx_q == LAST_IDX);
      end
      RESP: begin
        if (rsp_ready) begin
          if (dump_q && (idx_q != LAST_IDX)) idx_d  = idx_q + RBITS'(1);
          else                                dump_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_q      <= 1'b0;
      idx_q       <= '0;
      rf_rd_q     <= '0;
      rf_rd_din_q <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      dump_q      <= dump_d;
      idx_q       <= idx_d;
      rf_rd_q     <= rf_rd_d;
      rf_rd_din_q <= rf_rd_din_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rf_rd     = rf_rd_q;
  assign rf_rd_din = rf_rd_din_q;
  assign rf_rs     = idx_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: attached 16x16 register file with r0 tied to
// zero, plus an architectural model of register contents and expected beats.
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_halted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_addr;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [15:0] rf_rd_din;
  logic [3:0]  rf_rs;
  logic [15:0] rf_rs_dout;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;

  logic [15:0] ref_regs [16];
  logic [3:0]  obs_addr [$];
  logic [15:0] obs_data [$];
  logic        obs_last [$];

  regfile_debug_port dut (
    .clk(clk), .reset(reset), .core_halted(core_halted),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_rd_din(rf_rd_din),
    .rf_rs(rf_rs), .rf_rs_dout(rf_rs_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached register file: r0 reads zero and ignores writes
  logic [15:0] rf_mem [16];
  assign rf_rs_dout = (rf_rs == 4'd0) ? 16'h0000 : rf_mem[rf_rs];
  always @(posedge clk) begin
    if (rf_we && rf_rd != 4'd0) rf_mem[rf_rd] <= rf_rd_din;
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_accept: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  // Collects response beats; mode 0 ready high, 1 toggling, 2 random
  task automatic drain(input int nbeats, input int mode, output int got,
                       output int unstable, output int cyc);
    logic [3:0]  pa = '0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    bit          pend = 1'b0;
    bit          tog = 1'b1;
    got = 0; unstable = 0; cyc = 0;
    obs_addr.delete(); obs_data.delete(); obs_last.delete();
    while (got < nbeats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pend && (rsp_valid !== 1'b1 || rsp_addr !== pa || rsp_data !== pd || rsp_last !== pl))
        unstable++;
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       begin rsp_ready = tog; tog = ~tog; end
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (rsp_valid === 1'b1) begin
        if (rsp_ready) begin
          obs_addr.push_back(rsp_addr);
          obs_data.push_back(rsp_data);
          obs_last.push_back(rsp_last);
          got++;
          pend = 1'b0;
        end else begin
          pa = rsp_addr; pd = rsp_data; pl = rsp_last; pend = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; core_halted = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 4'h0; cmd_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, rsp_last, rf_we, busy, rsp_addr, rsp_data, rf_rd, rf_rd_din, rf_rs} !== '0) begin
      bad++;
      $display("FAIL reset_state: outputs=%h required 0",
               {cmd_ready, rsp_valid, rsp_last, rf_we, busy, rsp_addr, rsp_data, rf_rd, rf_rd_din, rf_rs});
    end
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write();
    int got, unst, cyc, w0;
    rsp_ready = 1'b1;
    w0 = we_cnt;
    issue(2'b10, 4'd3, 16'hBEEF);
    @(negedge clk);
    total++;
    if ({rf_we, rf_rd, rf_rd_din, busy, rsp_valid} !== {1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL write_pulse: we=%b rd=%h din=%h busy=%b vld=%b required 1 3 beef 1 0",
               rf_we, rf_rd, rf_rd_din, busy, rsp_valid);
    end
    drain(1, 0, got, unst, cyc);
    total++;
    if (got !== 1 || cyc !== 1 || obs_addr[0] !== 4'd3 || obs_data[0] !== 16'hBEEF || obs_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL write_rsp: got=%0d cyc=%0d addr=%h data=%h last=%b required 1 1 3 beef 1",
               got, cyc, obs_addr[0], obs_data[0], obs_last[0]);
    end
    ref_regs[3] = 16'hBEEF;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || we_cnt - w0 !== 1) begin
      bad++;
      $display("FAIL write_done: ready=%b busy=%b we_pulses=%0d required 1 0 1", cmd_ready, busy, we_cnt - w0);
    end
  endtask

  task automatic test_read();
    int got, unst, cyc;
    issue(2'b01, 4'd3, 16'h0);
    drain(1, 0, got, unst, cyc);
    total++;
    if (got !== 1 || cyc !== 2 || obs_addr[0] !== 4'd3 || obs_data[0] !== ref_regs[3] || obs_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL read_rsp: got=%0d lat=%0d addr=%h data=%h last=%b required 1 2 3 %h 1",
               got, cyc, obs_addr[0], obs_data[0], obs_last[0], ref_regs[3]);
    end
  endtask

  task automatic test_write_r0();
    int got, unst, cyc;
    issue(2'b10, 4'd0, 16'h1234);
    drain(1, 0, got, unst, cyc);
    total++;
    if (got !== 1 || obs_addr[0] !== 4'd0 || obs_data[0] !== 16'h1234 || obs_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL r0_write_echo: got=%0d addr=%h data=%h last=%b required 1 0 1234 1",
               got, obs_addr[0], obs_data[0], obs_last[0]);
    end
    issue(2'b01, 4'd0, 16'h0);
    drain(1, 0, got, unst, cyc);
    total++;
    if (got !== 1 || obs_data[0] !== ref_regs[0]) begin
      bad++;
      $display("FAIL r0_read: got=%0d data=%h required 1 %h", got, obs_data[0], ref_regs[0]);
    end
  endtask

  task automatic test_dump();
    int got, unst, cyc;
    for (int i = 1; i < 16; i++) begin
      issue(2'b10, 4'(i), 16'(i * 16'h0101));
      drain(1, 0, got, unst, cyc);
      ref_regs[i] = 16'(i * 16'h0101);
    end
    issue(2'b11, 4'd0, 16'h0);
    drain(16, 1, got, unst, cyc);
    total++;
    if (got !== 16 || unst !== 0) begin
      bad++;
      $display("FAIL dump_toggle: beats=%0d unstable=%0d required 16 0", got, unst);
    end
    for (int i = 0; i < got; i++) begin
      total++;
      if (obs_addr[i] !== 4'(i) || obs_data[i] !== ref_regs[i] || obs_last[i] !== (i == 15)) begin
        bad++;
        $display("FAIL dump_beat%0d: addr=%h data=%h last=%b required %h %h %b",
                 i, obs_addr[i], obs_data[i], obs_last[i], 4'(i), ref_regs[i], (i == 15));
      end
    end
    issue(2'b11, 4'd0, 16'h0);
    drain(16, 0, got, unst, cyc);
    total++;
    if (got !== 16 || cyc !== 32 || obs_last[15] !== 1'b1 || obs_last[14] !== 1'b0) begin
      bad++;
      $display("FAIL dump_timing: beats=%0d last_beat_cycle=%0d required 16 32", got, cyc);
    end
  endtask

  task automatic test_halt();
    int got, unst, cyc, w0, ready_seen;
    w0 = we_cnt; ready_seen = 0;
    @(negedge clk);
    core_halted = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd5; cmd_wdata = 16'hDEAD;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || busy !== 1'b0) ready_seen++;
    end
    total++;
    if (ready_seen !== 0 || we_cnt !== w0) begin
      bad++;
      $display("FAIL unhalted_block: ready_or_busy_cycles=%0d we_pulses=%0d required 0 0", ready_seen, we_cnt - w0);
    end
    cmd_valid = 1'b0; core_halted = 1'b1;
    issue(2'b11, 4'd0, 16'h0);
    core_halted = 1'b0;
    drain(16, 0, got, unst, cyc);
    total++;
    if (got !== 16 || obs_data[15] !== ref_regs[15] || obs_last[15] !== 1'b1) begin
      bad++;
      $display("FAIL dump_after_unhalt: beats=%0d data15=%h required 16 %h", got, obs_data[15], ref_regs[15]);
    end
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd1;
    ready_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) ready_seen++;
    end
    total++;
    if (ready_seen !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_dump_block: accepting_cycles=%0d busy=%b required 0 0", ready_seen, busy);
    end
    cmd_valid = 1'b0; core_halted = 1'b1;
  endtask

  task automatic test_reset_mid();
    int got, unst, cyc;
    issue(2'b11, 4'd0, 16'h0);
    drain(4, 0, got, unst, cyc);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_addr !== 4'd4) begin
      bad++;
      $display("FAIL mid_dump_beat5: vld=%b addr=%h required 1 4", rsp_valid, rsp_addr);
    end
    rsp_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_addr !== 4'd0 || rf_rs !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset: vld=%b busy=%b addr=%h rs=%h required 0 0 0 0", rsp_valid, busy, rsp_addr, rf_rs);
    end
    reset = 1'b0; rsp_ready = 1'b1;
    issue(2'b01, 4'd7, 16'h0);
    drain(1, 0, got, unst, cyc);
    total++;
    if (got !== 1 || cyc !== 2 || obs_addr[0] !== 4'd7 || obs_data[0] !== ref_regs[7] || obs_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL read_after_reset: got=%0d lat=%0d addr=%h data=%h required 1 2 7 %h",
               got, cyc, obs_addr[0], obs_data[0], ref_regs[7]);
    end
  endtask

  task automatic test_nop();
    int w0, vld;
    w0 = we_cnt; vld = 0;
    issue(2'b00, 4'd5, 16'hAAAA);
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) vld++;
    end
    total++;
    if (vld !== 0 || we_cnt !== w0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL nop_silent: active_cycles=%0d we_pulses=%0d ready=%b required 0 0 1", vld, we_cnt - w0, cmd_ready);
    end
  endtask

  task automatic test_random();
    int got, unst, cyc, n, idle_vld;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic [3:0]  ea [$];
    logic [15:0] ed [$];
    logic        el [$];
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3)); addr = 4'($urandom); wd = 16'($urandom);
      ea.delete(); ed.delete(); el.delete();
      case (op)
        2'b01: begin ea.push_back(addr); ed.push_back(ref_regs[addr]); el.push_back(1'b1); end
        2'b10: begin
          ea.push_back(addr); ed.push_back(wd); el.push_back(1'b1);
          if (addr != 4'd0) ref_regs[addr] = wd;
        end
        2'b11: for (int i = 0; i < 16; i++) begin
          ea.push_back(4'(i)); ed.push_back(ref_regs[i]); el.push_back(i == 15);
        end
        default: ;
      endcase
      n = ea.size();
      issue(op, addr, wd);
      if (n == 0) begin
        idle_vld = 0;
        repeat (3) begin
          @(negedge clk);
          if (rsp_valid !== 1'b0) idle_vld++;
        end
        total++;
        if (idle_vld !== 0) begin bad++; $display("FAIL rnd_nop%0d: valid_cycles=%0d required 0", k, idle_vld); end
      end else begin
        drain(n, 2, got, unst, cyc);
        total++;
        if (got !== n || unst !== 0) begin
          bad++;
          $display("FAIL rnd_cmd%0d: beats=%0d unstable=%0d required %0d 0", k, got, unst, n);
        end
        for (int i = 0; i < got; i++) begin
          total++;
          if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i] || obs_last[i] !== el[i]) begin
            bad++;
            $display("FAIL rnd_cmd%0d_beat%0d: addr=%h data=%h last=%b required %h %h %b",
                     k, i, obs_addr[i], obs_data[i], obs_last[i], ea[i], ed[i], el[i]);
          end
        end
      end
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;
    test_reset();
    test_write();
    test_read();
    test_write_r0();
    test_dump();
    test_halt();
    test_reset_mid();
    test_nop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_debug_port.md
Name: regfile_debug_port

Overview:
- Debug-side initiator for the 16x16 CPU register file.
- Accepts host commands over a valid/ready channel while the core is halted: single read, single write, or a full dump of r0..r15.
- Drives the register file's write port (we/rd/rd_din) and one read port (rs/dout).
- Returns one response beat per read, write, or dump element over a valid/ready response channel.
- Sits between the host debug bridge and the register file. Top level muxes its rf_* outputs onto the register file ports when core_halted=1.

Parameters:
- BITS, 16, register data width
- RBITS, 4, register index width
- NREG, 16, register count; dump covers indices 0..NREG-1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- core_halted  input  1  core stopped; commands are accepted only when high
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  block accepts command this cycle
- cmd_op  input  2  00 nop, 01 read, 10 write, 11 dump
- cmd_addr  input  RBITS  register index for read/write
- cmd_wdata  input  BITS  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  host accepts response
- rsp_addr  output  RBITS  register index of response
- rsp_data  output  BITS  read data, or echoed write data
- rsp_last  output  1  final beat of command (1 for read/write; 1 only on index NREG-1 for dump)
- rf_we  output  1  register file write enable (1-cycle pulse)
- rf_rd  output  RBITS  register file write index
- rf_rd_din  output  BITS  register file write data
- rf_rs  output  RBITS  register file read index
- rf_rs_dout  input  BITS  register file combinational read data
- busy  output  1  state != IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; cmd_ready=0, rsp_valid=0, rsp_last=0, rf_we=0, busy=0. rsp_addr, rsp_data, rf_rd, rf_rd_din, rf_rs, and the dump counter all =0. Reset mid-command abandons the command with no response.
- States: IDLE, WRITE, READ, RESP.
- cmd_ready = core_halted & (state==IDLE) & ~reset. A command is accepted on cmd_valid & cmd_ready; op, addr and wdata are latched on accept.
- IDLE transitions on accept:
  - op 01 -> READ, index = cmd_addr.
  - op 10 -> WRITE.
  - op 11 -> READ, index = 0, dump flag set.
  - op 00 -> stays IDLE; consumed silently, no response.
- WRITE (1 cycle):
  - rf_we=1, rf_rd=addr, rf_rd_din=wdata.
  - Load rsp_addr=addr, rsp_data=wdata, rsp_last=1.
  - -> RESP.
  - A write to index 0 still pulses rf_we; the register file discards it, and the response still echoes wdata.
- READ (1 cycle):
  - rf_rs=index; capture rf_rs_dout into rsp_data, rsp_addr=index.
  - rsp_last = ~dump | (index==NREG-1).
  - -> RESP.
- RESP:
  - rsp_valid=1; rsp_addr, rsp_data and rsp_last are held stable until rsp_ready.
  - On handshake: if dump & index!=NREG-1, then index+1 -> READ; otherwise -> IDLE and the dump flag clears.
- rf_we is 0 in every state except WRITE. rf_rs holds its last value outside READ.
- Latency with rsp_ready held high:
  - Accept at cycle N, rf_we or capture at N+1, rsp_valid at N+2, cmd_ready again at N+3.
  - Dump: beats at N+2, N+4, ..., N+32; rsp_last on beat 16.
- Backpressure: rsp_ready=0 holds RESP indefinitely with no change to rsp_*; no register file access occurs while waiting.
- core_halted falling mid-command: the current command, including a full dump, runs to completion. Only new acceptance is blocked.
- Index counter is RBITS wide. Dump termination is by compare with NREG-1, never by wrap-around.
- Host must not change cmd_* while stalled; the block samples them only on accept.

Test Plan:
- Reset, then halted=1; write op, addr=3, wdata=16'hBEEF -> rf_we=1 for exactly 1 cycle with rf_rd=3 and rf_rd_din=BEEF; one rsp beat with addr=3, data=BEEF, last=1.
- Read addr=3 after the above (register file model attached) -> rsp_data=16'hBEEF, rsp_last=1, rsp_valid 2 cycles after accept.
- Write addr=0, wdata=16'h1234, then read addr=0 -> write rsp echoes 1234; read rsp_data=0.
- Preload rN = N*16'h0101, issue dump with rsp_ready toggling 1/0 each cycle -> 16 beats, addr 0..15, data 0,0101,...,0F0F (r0 reads 0), last only on addr 15; rsp_* stable while not ready.
- core_halted=0 with cmd_valid=1 -> cmd_ready=0, no rf_we. Deassert halted mid-dump -> all 16 beats still delivered; the next command is not accepted.
- Assert reset during RESP of a dump at beat 5 -> next cycle rsp_valid=0, busy=0, state IDLE; a new read after reset works normally. A nop op is accepted with no response and no rf_we.
